// File: rtl/riscv_pkg.sv
// Shared core definitions for the fetch stage.
// Provides datapath widths, the reset PC default, the canonical NOP encoding,
// the buffered fetch entry type and small PC arithmetic helpers.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] INSTR_NOP        = 32'h0000_0013;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Address of the following word; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch stage.
// First-word-fall-through FIFO of fetch_entry_t whose head is read straight from
// registered storage, so a pushed word becomes visible the cycle after the push.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, push_data write one entry
//   pop             remove the head entry (ignored when empty)
//   flush           drop every entry; wins over push and pop
//   head            current head entry (valid when !empty)
//   occupancy       number of stored entries
//   full, empty     status flags
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fetch_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               pop_s;
    logic               push_s;

    // Circular pointer increment over a possibly non-power-of-two depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign occupancy = count_r;
    assign head      = mem_r[rd_ptr_r];

    // A push into a full buffer is only taken when the head leaves in the same
    // cycle; the write slot then equals the slot being read out.
    assign pop_s  = pop && !empty;
    assign push_s = push && (!full || pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared to NOPs so the head never shows stale X data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{instr: INSTR_NOP, pc: RESET_PC_DEFAULT};
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the core.
// Owns the fetch PC, issues word requests on a req/gnt/rvalid instruction memory
// port, buffers returned words tagged with their PC and hands them to decode on
// a valid/ready handshake. Redirects flush the buffer and drop in-flight replies.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req, imem_addr              request and its word address
//   imem_gnt                         request accepted
//   imem_rvalid, imem_rdata          in-order response
//   redirect_valid, redirect_pc      taken branch/jump and its target
//   instr_valid, instr, instr_pc     instruction to decode
//   instr_ready                      decode consumes the instruction
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_r;
    logic [XLEN-1:0]  resp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] discard_r;

    logic [CNT_W-1:0] outstanding_nxt_s;
    logic [CNT_W-1:0] discard_nxt_s;
    logic [SUM_W-1:0] credit_sum_s;
    logic             req_s;
    logic             handshake_s;
    logic             resp_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;
    logic [CNT_W-1:0] occupancy_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    // Request only while buffered plus in-flight words leave room for one more.
    always_comb begin
        credit_sum_s = SUM_W'(occupancy_s) + SUM_W'(outstanding_r);
        if (rst || redirect_valid) begin
            req_s = 1'b0;
        end else if (credit_sum_s < SUM_W'(DEPTH)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    assign handshake_s = req_s && imem_gnt;
    // Responses with nothing in flight are spurious and have no effect.
    assign resp_s      = imem_rvalid && (outstanding_r != {CNT_W{1'b0}});
    // A response arriving with a redirect belongs to the abandoned path.
    assign accept_s    = resp_s && (discard_r == {CNT_W{1'b0}}) && !redirect_valid;
    assign push_s      = accept_s && (!fifo_full_s || pop_s);
    assign pop_s       = !fifo_empty_s && instr_ready;

    assign push_entry_s = '{instr: imem_rdata, pc: resp_pc_r};

    // Next in-flight count from issued and returned words.
    always_comb begin
        case ({handshake_s, resp_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_W'(1);
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_W'(1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Next discard count. The in-flight count already includes words marked for
    // discard, so a redirect marks every word still in flight after this cycle.
    always_comb begin
        if (redirect_valid) begin
            if (resp_s) begin
                discard_nxt_s = outstanding_r - CNT_W'(1);
            end else begin
                discard_nxt_s = outstanding_r;
            end
        end else if (resp_s && (discard_r != {CNT_W{1'b0}})) begin
            discard_nxt_s = discard_r - CNT_W'(1);
        end else begin
            discard_nxt_s = discard_r;
        end
    end

    // Fetch PC: follows redirects, otherwise advances on every accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= align_word(redirect_pc);
        end else if (handshake_s) begin
            fetch_pc_r <= next_word(fetch_pc_r);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Response PC: tags each accepted word with the address it was fetched from.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            resp_pc_r <= align_word(redirect_pc);
        end else if (push_s) begin
            resp_pc_r <= next_word(resp_pc_r);
        end else begin
            resp_pc_r <= resp_pc_r;
        end
    end

    // In-flight and discard counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= {CNT_W{1'b0}};
            discard_r     <= {CNT_W{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head      (head_s),
        .occupancy (occupancy_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign imem_req    = req_s;
    assign imem_addr   = fetch_pc_r;
    assign instr_valid = !fifo_empty_s;
    assign instr       = head_s.instr;
    assign instr_pc    = head_s.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit.
// The reference model tracks words by the address they were requested from:
// a queue of in-flight requests (each possibly marked as dropped by a redirect)
// and a queue of delivered instructions, plus the next fetch address.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned gcyc;
        bit          drop;
    } flight_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } delivered_t;

    flight_t     inflight[$];
    delivered_t  deliv_q[$];
    logic [31:0] model_pc;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic run_cycle(input int gnt_pct, input int rv_pct, input int rdy_pct,
                             input int redir_pct, input int rst_pct);
        logic       exp_req;
        flight_t    h;
        delivered_t d;
        @(negedge clk);
        rst            = chance(rst_pct);
        redirect_valid = chance(redir_pct);
        if (chance(25)) begin
            redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000F);
        end else begin
            redirect_pc = $urandom();
        end
        imem_gnt    = chance(gnt_pct);
        instr_ready = chance(rdy_pct);
        if (inflight.size() != 0 && inflight[0].gcyc < cyc && chance(rv_pct)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(inflight[0].addr);
        end else if (inflight.size() == 0 && chance(5)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom();
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end
        #1;
        exp_req = !rst && !redirect_valid && ((deliv_q.size() + inflight.size()) < DEPTH);
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        check("imem_addr", imem_addr, model_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, deliv_q.size() != 0});
        if (deliv_q.size() != 0) begin
            check("instr", instr, deliv_q[0].word);
            check("instr_pc", instr_pc, deliv_q[0].pc);
        end
        if (rst) begin
            model_pc = RESET_PC;
            deliv_q.delete();
            inflight.delete();
        end else begin
            if (deliv_q.size() != 0 && instr_ready) begin
                void'(deliv_q.pop_front());
            end
            if (imem_rvalid && inflight.size() != 0) begin
                h = inflight.pop_front();
                if (!h.drop && !redirect_valid) begin
                    d.word = mem_word(h.addr);
                    d.pc   = h.addr;
                    deliv_q.push_back(d);
                end
            end
            if (redirect_valid) begin
                deliv_q.delete();
                foreach (inflight[i]) inflight[i].drop = 1'b1;
                model_pc = {redirect_pc[31:2], 2'b00};
            end else if (exp_req && imem_gnt) begin
                h.addr = model_pc;
                h.gcyc = cyc;
                h.drop = 1'b0;
                inflight.push_back(h);
                model_pc = model_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0000_0000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        instr_ready    = 1'b0;
        model_pc       = RESET_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_instr_valid", {31'b0, instr_valid}, 32'h0000_0000);
        check("reset_imem_req", {31'b0, imem_req}, 32'h0000_0000);
        check("reset_imem_addr", imem_addr, RESET_PC);

        // Streaming: always granted, fastest response, decode always ready.
        repeat (30) run_cycle(100, 100, 100, 0, 0);
        // Decode stalls: credits exhaust, head must hold.
        repeat (12) run_cycle(100, 100, 0, 0, 0);
        repeat (10) run_cycle(100, 100, 100, 0, 0);
        // Memory refuses grants.
        repeat (8) run_cycle(0, 100, 100, 0, 0);
        // Redirect-heavy traffic with back-to-back pulses.
        repeat (300) run_cycle(90, 80, 80, 30, 0);
        // General random mix including resets mid-flight.
        repeat (2000) run_cycle(60, 60, 70, 5, 1);
        repeat (500) run_cycle(90, 90, 30, 10, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
